// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the instruction fetch path.
//   fetch_state_t    : fetch sequencer FSM state encoding
//   INSTR_W          : assembled instruction width (two bytes)
//   BYTE_W           : instruction memory data width
//   RESET_PC_DEFAULT : default program counter value after reset
// ---------------------------------------------------------------------------
package risc_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  // S_HI    : strobe the byte at pc
  // S_LO    : capture byte at pc, strobe the byte at pc+1
  // S_CAP   : capture byte at pc+1, assemble and present the word
  // S_VALID : hold the word until decode takes it
  typedef enum logic [1:0] {
    S_HI    = 2'd0,
    S_LO    = 2'd1,
    S_CAP   = 2'd2,
    S_VALID = 2'd3
  } fetch_state_t;

endpackage : risc_pkg

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch controller for a byte-wide synchronous instruction memory.
// Each instruction is two bytes read at pc and pc+1; the first byte lands in
// instr[15:8]. The assembled word is offered to decode over valid/ready.
// The module owns the program counter, follows redirects (highest priority,
// any state) and stops starting new fetches while halt is high.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   mem_rd_en      out  memory read strobe
//   mem_addr       out  memory byte address (pc when idle)
//   mem_rdata      in   read data, valid the cycle after the strobe
//   instr          out  assembled instruction {byte@pc, byte@pc+1}
//   instr_pc       out  pc of the presented instruction
//   instr_valid    out  instr/instr_pc hold a fetched instruction
//   instr_ready    in   decode accepts the instruction this cycle
//   redirect_valid in   single-cycle pc change request
//   redirect_pc    in   redirect target (any alignment)
//   halt           in   level; blocks the start of a new fetch
// ---------------------------------------------------------------------------
module fetch_sequencer
  import risc_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [BYTE_W-1:0]    mem_rdata,
  output logic [INSTR_W-1:0]   instr,
  output logic [ADDR_W-1:0]    instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  input  logic                 halt
);

  fetch_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]     pc_reg, pc_next;
  logic [BYTE_W-1:0]     hi_byte_reg, hi_byte_next;
  logic [INSTR_W-1:0]    instr_reg, instr_next;
  logic [ADDR_W-1:0]     instr_pc_reg, instr_pc_next;
  logic                  valid_reg, valid_next;

  // pc arithmetic is modulo 2^ADDR_W; the carry out is simply dropped.
  logic [ADDR_W-1:0]     pc_plus1;
  logic [ADDR_W-1:0]     pc_plus2;

  assign pc_plus1 = pc_reg + ADDR_W'(1);
  assign pc_plus2 = pc_reg + ADDR_W'(2);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_HI;
      pc_reg       <= RESET_PC;
      hi_byte_reg  <= '0;
      instr_reg    <= '0;
      instr_pc_reg <= RESET_PC;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      hi_byte_reg  <= hi_byte_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    hi_byte_next  = hi_byte_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    mem_rd_en     = 1'b0;
    mem_addr      = pc_reg;

    unique case (state_reg)
      S_HI: begin
        if (!halt) begin
          mem_rd_en  = 1'b1;
          state_next = S_LO;
        end
      end

      S_LO: begin
        // Byte at pc arrives now; the pc+1 read goes out in the same cycle.
        hi_byte_next = mem_rdata;
        mem_rd_en    = 1'b1;
        mem_addr     = pc_plus1;
        state_next   = S_CAP;
      end

      S_CAP: begin
        instr_next    = {hi_byte_reg, mem_rdata};
        instr_pc_next = pc_reg;
        valid_next    = 1'b1;
        state_next    = S_VALID;
      end

      S_VALID: begin
        if (instr_ready) begin
          valid_next = 1'b0;
          pc_next    = pc_plus2;
          state_next = S_HI;
        end
      end

      default: begin
        state_next = S_HI;
      end
    endcase

    // A redirect overrides everything above. If it coincides with a
    // handshake the instruction is still consumed (valid drops either way),
    // only the pc increment is replaced by the target. Any strobe issued in
    // this cycle is harmless: the state restarts at S_HI and the returned
    // byte is never captured.
    if (redirect_valid) begin
      state_next = S_HI;
      pc_next    = redirect_pc;
      valid_next = 1'b0;
    end

    // No memory traffic while reset is held.
    if (rst) begin
      mem_rd_en = 1'b0;
    end
  end

  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;

endmodule : fetch_sequencer
